// File: rtl/noc_inject_arbiter.sv
// Round-robin, burst-granular arbiter sharing one NoC injection port among NUM_REQ requesters,
// with a registered output stage that holds under back-pressure and a credit cap on beats in flight.
module noc_inject_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned D_W        = 512,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned MAX_CREDIT = 16,
   localparam int unsigned ID_W      = $clog2(NUM_REQ),
   localparam int unsigned CNT_W     = $clog2(MAX_CREDIT + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*D_W-1:0] req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   inj_valid,
   output logic [D_W-1:0]         inj_data,
   output logic [ID_W-1:0]        inj_id,
   input  logic                   inj_ready,
   input  logic                   done_in,
   output logic [CNT_W-1:0]       credit_cnt,
   output logic                   busy,
   output logic                   credit_err
);

   localparam int unsigned BW = $clog2(BURST_LEN + 1);

   typedef enum logic {StIdle, StGrant} state_t;

   state_t           r_state;
   logic [ID_W-1:0]  r_grant;
   logic [ID_W-1:0]  r_last_grant;
   logic [BW-1:0]    r_beat_cnt;
   logic [CNT_W-1:0] r_credit;
   logic             r_inj_valid;
   logic [D_W-1:0]   r_inj_data;
   logic [ID_W-1:0]  r_inj_id;
   logic             r_credit_err;

   logic             w_found;
   logic [ID_W-1:0]  w_pick;
   logic             w_credit_ok;
   logic             w_slot_free;
   logic             w_accept;
   logic             w_cred_inc;

   // First valid requester after the last grant, wrapping around.
   always_comb begin
      int unsigned idx;
      w_found = 1'b0;
      w_pick  = '0;
      idx     = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(r_last_grant) + off) % NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_pick  = ID_W'(idx);
         end
      end
   end

   assign w_credit_ok = (r_credit != '0);
   assign w_slot_free = !r_inj_valid || inj_ready;
   assign w_accept    = (r_state == StGrant) && req_valid[r_grant] && w_slot_free && w_credit_ok;
   // A return at full credit is a protocol error and must not wrap the counter.
   assign w_cred_inc  = done_in && (r_credit != CNT_W'(MAX_CREDIT));

   always_comb begin
      req_ready = '0;
      if (w_accept) req_ready[r_grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_grant      <= '0;
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_beat_cnt   <= '0;
         r_credit     <= CNT_W'(MAX_CREDIT);
         r_inj_valid  <= 1'b0;
         r_inj_data   <= '0;
         r_inj_id     <= '0;
         r_credit_err <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_found && w_credit_ok) begin
                  r_grant      <= w_pick;
                  r_last_grant <= w_pick;
                  r_beat_cnt   <= '0;
                  r_state      <= StGrant;
               end
            end
            StGrant: begin
               if (!req_valid[r_grant]) begin
                  r_state <= StIdle;
               end else if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (r_beat_cnt == BW'(BURST_LEN - 1)) r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase

         if (w_accept) begin
            r_inj_valid <= 1'b1;
            r_inj_data  <= req_data[r_grant*D_W +: D_W];
            r_inj_id    <= r_grant;
         end else if (inj_ready) begin
            r_inj_valid <= 1'b0;
         end

         unique case ({w_accept, w_cred_inc})
            2'b10:   r_credit <= r_credit - 1'b1;
            2'b01:   r_credit <= r_credit + 1'b1;
            default: r_credit <= r_credit;
         endcase

         if (done_in && !w_cred_inc) r_credit_err <= 1'b1;
      end
   end

   assign inj_valid  = r_inj_valid;
   assign inj_data   = r_inj_data;
   assign inj_id     = r_inj_id;
   assign credit_cnt = r_credit;
   assign busy       = (r_state == StGrant) || r_inj_valid;
   assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: a cycle-level reference model predicts handshakes and
// pushes expected beats; a separate monitor pops and compares each beat the router accepts.
module tb_noc_inject_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int BL = 8;
   localparam int MC = 16;
   localparam int IW = 2;
   localparam int CW = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             inj_valid;
   logic [DW-1:0]    inj_data;
   logic [IW-1:0]    inj_id;
   logic             inj_ready;
   logic             done_in;
   logic [CW-1:0]    credit_cnt;
   logic             busy;
   logic             credit_err;

   noc_inject_arbiter #(
      .NUM_REQ   (NR),
      .D_W       (DW),
      .BURST_LEN (BL),
      .MAX_CREDIT(MC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .inj_valid (inj_valid),
      .inj_data  (inj_data),
      .inj_id    (inj_id),
      .inj_ready (inj_ready),
      .done_in   (done_in),
      .credit_cnt(credit_cnt),
      .busy      (busy),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [IW-1:0] id;
   } beat_t;

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t exp_q[$];
   int    id_log[$];

   // Reference model state
   bit            m_grant_st;
   int            m_grant, m_last, m_beats, m_credit, m_id;
   bit            m_vld, m_err;
   logic [DW-1:0] m_data;
   int            pool;

   // Stimulus controls
   bit            rand_mode;
   int            budget[NR];
   int            ready_mode;
   int            done_mode;
   bit            force_done;
   bit            src_v[NR];
   logic [DW-1:0] src_d[NR];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_grant_st = 0; m_grant = 0; m_last = NR - 1; m_beats = 0;
      m_credit = MC; m_vld = 0; m_id = 0; m_data = '0; m_err = 0;
      exp_q.delete(); pool = 0; rand_mode = 0; force_done = 0;
      for (int i = 0; i < NR; i++) begin budget[i] = 0; src_v[i] = 0; end
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 1'b0; req_valid = '0; inj_ready = 1'b0; done_in = 1'b0;
      model_reset();
      #1;
      chk("rst_inj_valid", 64'(inj_valid), 64'd0);
      chk("rst_credit", 64'(credit_cnt), 64'(MC));
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_credit_err", 64'(credit_err), 64'd0);
      chk("rst_inj_id", 64'(inj_id), 64'd0);
      chk("rst_inj_data", 64'(inj_data), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic step();
      logic [NR-1:0] exp_rdy;
      bit acc, found;
      int c0;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
         if (rand_mode) src_v[i] = src_v[i] ? ($urandom_range(9) != 0) : ($urandom_range(9) < 4);
         else           src_v[i] = budget[i] > 0;
         req_valid[i] = src_v[i];
         req_data[i*DW +: DW] = src_d[i];
      end
      inj_ready = (ready_mode == 2) ? ($urandom_range(3) != 0) : (ready_mode == 1);
      done_in = force_done ||
                (pool > 0 && (done_mode == 1 || (done_mode == 2 && $urandom_range(1) == 1)));
      #1;
      exp_rdy = '0;
      if (m_grant_st && req_valid[m_grant] && (!m_vld || inj_ready) && m_credit > 0)
         exp_rdy[m_grant] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("inj_valid", 64'(inj_valid), 64'(m_vld));
      if (m_vld) begin
         chk("inj_data_hold", 64'(inj_data), 64'(m_data));
         chk("inj_id_hold", 64'(inj_id), 64'(m_id));
      end
      chk("credit_cnt", 64'(credit_cnt), 64'(m_credit));
      chk("busy", 64'(busy), 64'(m_grant_st || m_vld));
      chk("credit_err", 64'(credit_err), 64'(m_err));

      c0  = m_credit;
      acc = exp_rdy != '0;
      if (m_vld && inj_ready) pool++;
      if (acc) begin
         exp_q.push_back('{d: src_d[m_grant], id: IW'(m_grant)});
         m_vld = 1; m_data = src_d[m_grant]; m_id = m_grant;
         budget[m_grant]--;
         src_d[m_grant] = $urandom;
      end else if (inj_ready) begin
         m_vld = 0;
      end
      if (done_in) begin
         if (m_credit == MC) m_err = 1;
         else m_credit++;
         if (pool > 0) pool--;
      end
      if (acc) m_credit--;

      if (!m_grant_st) begin
         found = 0;
         if (req_valid != '0 && c0 > 0) begin
            for (int off = 1; off <= NR; off++) begin
               int idx;
               idx = (m_last + off) % NR;
               if (!found && req_valid[idx]) begin
                  found = 1; m_grant = idx; m_last = idx; m_beats = 0; m_grant_st = 1;
               end
            end
         end
      end else if (!req_valid[m_grant]) begin
         m_grant_st = 0;
      end else if (acc) begin
         m_beats++;
         if (m_beats == BL) m_grant_st = 0;
      end
   endtask

   // Monitor: every beat the router takes must be the next one the model predicted.
   always @(negedge clk) begin
      if (rst === 1'b1 && inj_valid === 1'b1 && inj_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected_beat: got id %0d data %0h expected none", inj_id, inj_data);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("sb_data", 64'(inj_data), 64'(e.d));
            chk("sb_id", 64'(inj_id), 64'(e.id));
         end
         id_log.push_back(int'(inj_id));
      end
   end

   initial begin
      rst = 1'b0; req_valid = '0; req_data = '0; inj_ready = 1'b0; done_in = 1'b0;
      ready_mode = 1; done_mode = 0;
      for (int i = 0; i < NR; i++) src_d[i] = $urandom;
      model_reset();

      // Single requester, three beats
      do_reset();
      id_log.delete();
      budget[1] = 3;
      repeat (8) step();
      chk("p1_credit", 64'(credit_cnt), 64'd13);
      chk("p1_beats", 64'(id_log.size()), 64'd3);
      foreach (id_log[k]) chk("p1_id", 64'(id_log[k]), 64'd1);

      // All requesters continuously valid: full bursts in round-robin order
      do_reset();
      id_log.delete();
      done_mode = 1;
      for (int i = 0; i < NR; i++) budget[i] = 1000;
      repeat (50) step();
      if (id_log.size() < 40) begin
         chk("p2_beat_count", 64'(id_log.size()), 64'd40);
      end else begin
         for (int k = 0; k < 40; k++) chk("p2_burst_order", 64'(id_log[k]), 64'((k / BL) % NR));
      end

      // Back-pressure mid-burst
      ready_mode = 0;
      repeat (5) step();
      ready_mode = 1;
      repeat (10) step();

      // Credit exhaustion stalls inside a grant
      do_reset();
      id_log.delete();
      done_mode = 0;
      budget[0] = 3;
      repeat (8) step();
      for (int i = 1; i < NR; i++) budget[i] = 1000;
      repeat (30) step();
      chk("p4_accepted", 64'(id_log.size()), 64'd16);
      chk("p4_credit", 64'(credit_cnt), 64'd0);
      chk("p4_busy", 64'(busy), 64'd1);
      force_done = 1;
      repeat (3) step();
      force_done = 0;
      repeat (5) step();
      chk("p4_after_done", 64'(id_log.size()), 64'd19);

      // Early release hands over to the next requester; done at full credit is an error
      do_reset();
      id_log.delete();
      done_mode = 1;
      budget[2] = 3;
      budget[3] = 2;
      repeat (15) step();
      chk("p5_beats", 64'(id_log.size()), 64'd5);
      if (id_log.size() == 5) begin
         for (int k = 0; k < 5; k++) chk("p5_id", 64'(id_log[k]), (k < 3) ? 64'd2 : 64'd3);
      end
      force_done = 1;
      step();
      force_done = 0;
      step();
      chk("p5_credit_err", 64'(credit_err), 64'd1);
      repeat (3) step();
      chk("p5_err_sticky", 64'(credit_err), 64'd1);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < NR; i++) budget[i] = 1000;
      repeat (6) step();
      @(posedge clk); #3;
      rst = 1'b0; req_valid = '0; inj_ready = 1'b0; done_in = 1'b0;
      model_reset();
      #1;
      chk("p6_inj_valid", 64'(inj_valid), 64'd0);
      chk("p6_credit", 64'(credit_cnt), 64'(MC));
      chk("p6_credit_err", 64'(credit_err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      id_log.delete();
      for (int i = 0; i < NR; i++) budget[i] = 1000;
      repeat (4) step();
      if (id_log.size() == 0) chk("p6_restart_beats", 64'd0, 64'd1);
      else chk("p6_restart_id", 64'(id_log[0]), 64'd0);

      // Randomized traffic, then drain
      do_reset();
      rand_mode = 1; ready_mode = 2; done_mode = 2;
      repeat (3000) step();
      rand_mode = 0; ready_mode = 1;
      for (int i = 0; i < NR; i++) budget[i] = 0;
      repeat (20) step();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares one NoC injection port (the north/DDR input of a hoplite column) among NUM_REQ requesters, e.g. DDR read channels or prefetch engines.
- Round-robin, burst-granular arbitration.
- Registered output stage that holds data under ring back-pressure.
- Credit counter that caps packets in flight; credits return on the router's done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- D_W, 512, packet/data width in bits.
- BURST_LEN, 8, maximum beats per grant before forced re-arbitration (>=1).
- MAX_CREDIT, 16, maximum outstanding injected beats; credit counter width clog2(MAX_CREDIT+1).
- ID_W is a localparam, clog2(NUM_REQ).

Ports:
- clk  input  1  Single clock.
- rst  input  1  Asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  NUM_REQ  Per-requester beat valid.
- req_data  input  NUM_REQ*D_W  Flattened beats; requester i at bits [i*D_W +: D_W].
- req_ready  output  NUM_REQ  Per-requester beat accepted (one-hot or zero).
- inj_valid  output  1  Injection beat valid toward the router.
- inj_data  output  D_W  Injection beat.
- inj_id  output  ID_W  Source requester of inj_data.
- inj_ready  input  1  Router accepts the beat this cycle.
- done_in  input  1  One-cycle pulse per delivered beat; returns one credit.
- credit_cnt  output  clog2(MAX_CREDIT+1)  Available credits.
- busy  output  1  High in GRANT state or while inj_valid=1.
- credit_err  output  1  Sticky: done_in received while credit_cnt==MAX_CREDIT.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=NUM_REQ-1, beat_cnt=0.
  - credit_cnt=MAX_CREDIT.
  - inj_valid=0, inj_data=0, inj_id=0.
  - req_ready=0, busy=0, credit_err=0.
  - Reset mid-burst discards the held beat and all state.
- FSM IDLE:
  - If any req_valid and credit_cnt>0: pick the first valid requester searching from last_grant+1, wrapping modulo NUM_REQ.
  - Register it as grant, set last_grant=grant, beat_cnt=0, go to GRANT.
  - req_ready=0 throughout IDLE. Arbitration costs one cycle.
- FSM GRANT:
  - Define slot_free = !inj_valid || inj_ready.
  - req_ready[grant] = req_valid[grant] && slot_free && credit_cnt>0. All other req_ready bits are 0.
  - Accepted beat (req_valid & req_ready): next cycle inj_valid=1, inj_data=beat, inj_id=grant; beat_cnt++. Latency is 1 cycle from accept to inj_valid.
  - Exit to IDLE after the accepted beat where beat_cnt==BURST_LEN-1.
  - Exit to IDLE in any GRANT cycle where req_valid[grant]=0. The requester gave up its burst; no hold.
  - credit_cnt==0 while in GRANT: stay, stall (req_ready=0).
- Output stage:
  - inj_valid/inj_data/inj_id stay stable while inj_valid && !inj_ready.
  - inj_valid clears after a handshake with no new accept in the same cycle.
  - Back-to-back beats, one per cycle, when inj_ready is held high.
- Credits:
  - Decrement on each accepted requester beat; increment on done_in.
  - Both in the same cycle: unchanged.
  - Never underflows: no accept when credit_cnt==0.
  - done_in at MAX_CREDIT is ignored and sets credit_err.
- Fairness:
  - A requester granted last has lowest priority at the next arbitration.
  - No requester waits more than (NUM_REQ-1) bursts.

Test Plan:
- Reset then single requester: req_valid=4'b0010, 3 beats, inj_ready=1 → req_ready[1] high on cycles 2-4 after reset release; inj_valid beats D0,D1,D2 one cycle later with inj_id=1; credit_cnt 16→13.
- All four valid continuously, BURST_LEN=8, inj_ready=1 → grants in order 0,1,2,3,0; each burst exactly 8 beats; one idle arbitration cycle between bursts.
- Back-pressure: inj_ready=0 for 5 cycles mid-burst → inj_data/inj_id held constant; req_ready=0; no beat lost or duplicated; streaming resumes one beat per cycle once inj_ready=1.
- Credit exhaustion: MAX_CREDIT=4, no done_in → exactly 4 beats accepted, then stall with busy=1. One done_in pulse → one more beat. done_in coincident with an accept → credit_cnt unchanged.
- Early release and overflow: requester 2 drops req_valid after 3 beats → FSM returns to IDLE and requester 3 is granted next. done_in at credit_cnt=16 → credit_err=1 and stays 1 until reset.
- Async reset mid-burst: rst=0 while inj_valid=1 → inj_valid=0 immediately, credit_cnt=MAX_CREDIT; arbitration restarts at requester 0.
